// File: rtl/pe5_sched_pkg.sv
// Shared types and constants for the 5-lane sparse PE scheduler.
// FSM encoding, lane/mask geometry and the non_zero_num encoding.
package pe5_sched_pkg;
  localparam int MAC_DIM    = 5;
  localparam int SPAD_WIDTH = 64;
  localparam int ADDR_WIDTH = $clog2(SPAD_WIDTH);
  localparam int NUM_NODES  = 20;
  localparam int TAG_WIDTH  = $clog2(NUM_NODES);
  localparam int CNT_WIDTH  = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  localparam logic [2:0] NZ_NUM_1 = 3'd0;
  localparam logic [2:0] NZ_NUM_2 = 3'd1;
  localparam logic [2:0] NZ_NUM_3 = 3'd2;
  localparam logic [2:0] NZ_NUM_4 = 3'd3;
  localparam logic [2:0] NZ_NUM_5 = 3'd4;

  // An empty group still occupies lane 0, so 0 and 1 share a code.
  function automatic logic [2:0] nz_num(
    input logic [CNT_WIDTH-1:0] cnt
  );
    unique case (1'b1)
      (cnt <= 3'd1): nz_num = NZ_NUM_1;
      (cnt == 3'd2): nz_num = NZ_NUM_2;
      (cnt == 3'd3): nz_num = NZ_NUM_3;
      (cnt == 3'd4): nz_num = NZ_NUM_4;
      default:       nz_num = NZ_NUM_5;
    endcase
  endfunction
endpackage

// File: rtl/pe5_nz_scheduler_if.sv
// Request and PE-facing bundle of the non-zero scheduler.
// master: node loader side; slave: the scheduler itself.
interface pe5_nz_scheduler_if
  import pe5_sched_pkg::*;
;
  logic                          start;
  logic [SPAD_WIDTH-1:0]         nz_mask;
  logic [TAG_WIDTH-1:0]          node_tag;
  logic                          ready;
  logic [MAC_DIM*ADDR_WIDTH-1:0] non_zero_add_out;
  logic [2:0]                    non_zero_num;
  logic                          acc;
  logic                          done;
  logic                          issue_vd;
  logic [TAG_WIDTH-1:0]          tag_out;
  logic                          tag_vd;

  modport master (
    output start, nz_mask, node_tag,
    input  ready, non_zero_add_out,
    input  non_zero_num, acc, done,
    input  issue_vd, tag_out, tag_vd
  );

  modport slave (
    input  start, nz_mask, node_tag,
    output ready, non_zero_add_out,
    output non_zero_num, acc, done,
    output issue_vd, tag_out, tag_vd
  );
endinterface

// File: rtl/pe5_nz_scheduler_nz_lane_extract.sv
// Combinational picker of the 5 lowest set bits of a mask.
// i_mask in; o_addr (lane j at [j*6 +: 6]), o_cnt, o_rest out.
module nz_lane_extract
  import pe5_sched_pkg::*;
(
  input  logic [SPAD_WIDTH-1:0]         i_mask,
  output logic [MAC_DIM*ADDR_WIDTH-1:0] o_addr,
  output logic [CNT_WIDTH-1:0]          o_cnt,
  output logic [SPAD_WIDTH-1:0]         o_rest
);

  function automatic logic [ADDR_WIDTH-1:0] ffs(
    input logic [SPAD_WIDTH-1:0] m
  );
    ffs = '0;
    for (int i = SPAD_WIDTH - 1; i >= 0; i--)
      if (m[i]) ffs = ADDR_WIDTH'(i);
  endfunction

  logic [SPAD_WIDTH-1:0] w_m [MAC_DIM+1];
  logic [MAC_DIM-1:0]    w_hit;

  assign w_m[0] = i_mask;

  for (genvar j = 0; j < MAC_DIM; j++) begin : g_st
    assign w_hit[j] = |w_m[j];
    assign o_addr[j*ADDR_WIDTH +: ADDR_WIDTH] =
      w_hit[j] ? ffs(w_m[j]) : '0;
    // m & (m-1) clears the lowest set bit.
    assign w_m[j+1] = w_m[j] & (w_m[j] - SPAD_WIDTH'(1));
  end

  assign o_rest = w_m[MAC_DIM];

  always_comb begin
    o_cnt = '0;
    for (int j = 0; j < MAC_DIM; j++)
      if (w_hit[j]) o_cnt = o_cnt + CNT_WIDTH'(1);
  end
endmodule

// File: rtl/pe5_nz_scheduler.sv
// Walks a node's non-zero mask, up to 5 addresses per cycle, for the PE.
// clk/reset, io (slave); PE5_SCHED_PERF_EN adds grp_cnt/node_cnt.
module pe5_nz_scheduler
  import pe5_sched_pkg::*;
#(
  parameter int TAG_DLY = 1
) (
  input  logic clk,
  input  logic reset,
  pe5_nz_scheduler_if.slave io
`ifdef PE5_SCHED_PERF_EN
  ,
  output logic [15:0] grp_cnt,
  output logic [15:0] node_cnt
`endif
);

  state_t                        r_state;
  logic [SPAD_WIDTH-1:0]         r_rem;
  logic [TAG_WIDTH-1:0]          r_tag;
  logic [MAC_DIM*ADDR_WIDTH-1:0] r_addr;
  logic [2:0]                    r_num;
  logic                          r_acc;
  logic                          r_done;
  logic                          r_vd;
  logic [TAG_DLY-1:0]            r_vd_pipe;
  logic [TAG_WIDTH-1:0]          r_tag_pipe [TAG_DLY];

  logic                          w_idle;
  logic                          w_go;
  logic                          w_last;
  logic [SPAD_WIDTH-1:0]         w_src;
  logic [MAC_DIM*ADDR_WIDTH-1:0] w_addr;
  logic [CNT_WIDTH-1:0]          w_cnt;
  logic [SPAD_WIDTH-1:0]         w_rest;

  assign w_idle = (r_state == IDLE);
  // ISSUE always has a non-zero remainder to send.
  assign w_go   = w_idle ? io.start : 1'b1;
  assign w_src  = w_idle ? io.nz_mask : r_rem;
  assign w_last = (w_rest == '0);

  nz_lane_extract u_ext (
    .i_mask (w_src),
    .o_addr (w_addr),
    .o_cnt  (w_cnt),
    .o_rest (w_rest)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_rem     <= '0;
      r_tag     <= '0;
      r_addr    <= '0;
      r_num     <= NZ_NUM_1;
      r_acc     <= 1'b0;
      r_done    <= 1'b0;
      r_vd      <= 1'b0;
      r_vd_pipe <= '0;
      for (int i = 0; i < TAG_DLY; i++)
        r_tag_pipe[i] <= '0;
    end else begin
      r_vd   <= w_go;
      r_acc  <= w_go & ~w_idle;
      r_done <= w_go & w_last;
      r_num  <= w_go ? nz_num(w_cnt) : NZ_NUM_1;
      r_addr <= w_go ? w_addr : '0;
      if (w_go) begin
        r_rem   <= w_rest;
        r_state <= w_last ? IDLE : ISSUE;
      end
      if (w_go && w_idle)
        r_tag <= io.node_tag;
      // r_tag still holds the finishing node when its done is visible.
      r_vd_pipe[0]  <= r_done;
      r_tag_pipe[0] <= r_tag;
      for (int i = 1; i < TAG_DLY; i++) begin
        r_vd_pipe[i]  <= r_vd_pipe[i-1];
        r_tag_pipe[i] <= r_tag_pipe[i-1];
      end
    end
  end

`ifdef PE5_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      grp_cnt  <= '0;
      node_cnt <= '0;
    end else begin
      if (w_go && !(&grp_cnt))
        grp_cnt <= grp_cnt + 16'd1;
      if (w_go && w_last && !(&node_cnt))
        node_cnt <= node_cnt + 16'd1;
    end
  end
`endif

  assign io.ready            = w_idle;
  assign io.non_zero_add_out = r_addr;
  assign io.non_zero_num     = r_num;
  assign io.acc              = r_acc;
  assign io.done             = r_done;
  assign io.issue_vd         = r_vd;
  assign io.tag_vd           = r_vd_pipe[TAG_DLY-1];
  assign io.tag_out          = r_tag_pipe[TAG_DLY-1];
endmodule

// File: tb/tb_pe5_nz_scheduler.sv
// Scoreboard bench for pe5_nz_scheduler.
// Directed masks; a negedge monitor checks groups and tags by cycle.
module tb_pe5_nz_scheduler;
  import pe5_sched_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mon_en = 1'b0;
  always #5 clk = ~clk;

  pe5_nz_scheduler_if io ();

`ifdef PE5_SCHED_PERF_EN
  logic [15:0] grp_cnt;
  logic [15:0] node_cnt;
`endif

  pe5_nz_scheduler #(.TAG_DLY(1)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
`ifdef PE5_SCHED_PERF_EN
    ,
    .grp_cnt  (grp_cnt),
    .node_cnt (node_cnt)
`endif
  );

  typedef struct {
    int          cyc;
    logic [29:0] addr;
    logic [2:0]  num;
    logic        acc;
    logic        done;
  } grp_t;

  typedef struct {
    int         cyc;
    logic [4:0] tag;
  } tag_t;

  grp_t gq[$];
  tag_t tq[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [29:0] pk(
    input int a0, input int a1, input int a2,
    input int a3, input int a4
  );
    return {6'(a4), 6'(a3), 6'(a2), 6'(a1), 6'(a0)};
  endfunction

  task automatic chk(
    input string nm, input logic [63:0] act,
    input logic [63:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h",
               nm, cyc, act, exp);
    end
  endtask

  task automatic push(
    input int c, input logic [29:0] a, input int n,
    input logic acc, input logic done
  );
    grp_t g;
    g.cyc = c;
    g.addr = a;
    g.num = 3'(n);
    g.acc = acc;
    g.done = done;
    gq.push_back(g);
  endtask

  task automatic pusht(input int c, input int t);
    tag_t e;
    e.cyc = c;
    e.tag = 5'(t);
    tq.push_back(e);
  endtask

  always @(negedge clk) begin : mon
    grp_t g;
    tag_t e;
    if (mon_en) begin
      if (io.issue_vd) begin
        if (gq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexp_group @cyc %0d: got issue_vd 1 want 0",
                   cyc);
        end else begin
          g = gq.pop_front();
          chk("grp_cyc", 64'(cyc), 64'(g.cyc));
          chk("grp_addr", 64'(io.non_zero_add_out), 64'(g.addr));
          chk("grp_num", 64'(io.non_zero_num), 64'(g.num));
          chk("grp_acc", 64'(io.acc), 64'(g.acc));
          chk("grp_done", 64'(io.done), 64'(g.done));
        end
      end else begin
        chk("idle_outs",
            64'({io.non_zero_add_out, io.non_zero_num,
                 io.acc, io.done}), 64'(0));
      end
      if (io.tag_vd) begin
        if (tq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexp_tag @cyc %0d: got tag_vd 1 want 0",
                   cyc);
        end else begin
          e = tq.pop_front();
          chk("tag_cyc", 64'(cyc), 64'(e.cyc));
          chk("tag_val", 64'(io.tag_out), 64'(e.tag));
        end
      end
    end
  end

  task automatic accept(
    input logic [63:0] m, input int t, output int c0
  );
    int n = 0;
    io.start = 1'b1;
    io.nz_mask = m;
    io.node_tag = 5'(t);
    while (io.ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (io.ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got ready %b want 1", io.ready);
    end
    c0 = cyc;
  endtask

  task automatic step();
    @(negedge clk);
    io.start = 1'b0;
  endtask

  initial begin : stim
    int c0;
    int c1;
    io.start = 1'b0;
    io.nz_mask = '0;
    io.node_tag = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(io.ready), 64'(1));
    chk("rst_outs",
        64'({io.non_zero_add_out, io.non_zero_num, io.acc,
             io.done, io.issue_vd, io.tag_vd, io.tag_out}), 64'(0));
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // empty mask
    accept(64'h0, 3, c0);
    push(c0 + 1, pk(0, 0, 0, 0, 0), 0, 0, 1);
    pusht(c0 + 2, 3);
    step();
    chk("rdy_empty", 64'(io.ready), 64'(1));

    // single group {2,7,9}
    accept(64'h284, 7, c0);
    push(c0 + 1, pk(2, 7, 9, 0, 0), 2, 0, 1);
    pusht(c0 + 2, 7);
    step();
    chk("rdy_single", 64'(io.ready), 64'(1));

    // three groups
    accept(64'hFFF, 12, c0);
    push(c0 + 1, pk(0, 1, 2, 3, 4), 4, 0, 0);
    push(c0 + 2, pk(5, 6, 7, 8, 9), 4, 1, 0);
    push(c0 + 3, pk(10, 11, 0, 0, 0), 1, 1, 1);
    pusht(c0 + 4, 12);
    step();
    chk("rdy_3g_c1", 64'(io.ready), 64'(0));
    @(negedge clk);
    chk("rdy_3g_c2", 64'(io.ready), 64'(0));
    @(negedge clk);
    chk("rdy_3g_c3", 64'(io.ready), 64'(1));

    // back-to-back, start held
    accept(64'h3F, 1, c0);
    push(c0 + 1, pk(0, 1, 2, 3, 4), 4, 0, 0);
    push(c0 + 2, pk(5, 0, 0, 0, 0), 0, 1, 1);
    pusht(c0 + 3, 1);
    @(negedge clk);
    accept(64'h1, 2, c1);
    chk("b2b_accept_cyc", 64'(c1), 64'(c0 + 2));
    push(c1 + 1, pk(0, 0, 0, 0, 0), 0, 0, 1);
    pusht(c1 + 2, 2);
    step();

    // extreme bits
    accept(64'h8000_0000_0000_0001, 19, c0);
    push(c0 + 1, pk(0, 63, 0, 0, 0), 1, 0, 1);
    pusht(c0 + 2, 19);
    step();

    // all ones: 13 groups
    accept({64{1'b1}}, 5, c0);
    for (int k = 1; k <= 12; k++)
      push(c0 + k, pk(5*k-5, 5*k-4, 5*k-3, 5*k-2, 5*k-1),
           4, k > 1, 0);
    push(c0 + 13, pk(60, 61, 62, 63, 0), 3, 1, 1);
    pusht(c0 + 14, 5);
    step();
    repeat (14) @(negedge clk);
    chk("rdy_all1", 64'(io.ready), 64'(1));

    // reset after the 4th group
    accept({64{1'b1}}, 6, c0);
    for (int k = 1; k <= 4; k++)
      push(c0 + k, pk(5*k-5, 5*k-4, 5*k-3, 5*k-2, 5*k-1),
           4, k > 1, 0);
    step();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", 64'(io.ready), 64'(1));
    chk("vd_after_rst", 64'({io.issue_vd, io.tag_vd}), 64'(0));
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // normal node after reset
    accept(64'h30, 9, c0);
    push(c0 + 1, pk(4, 5, 0, 0, 0), 1, 0, 1);
    pusht(c0 + 2, 9);
    step();
    repeat (5) @(negedge clk);

    chk("grp_q_empty", 64'(gq.size()), 64'(0));
    chk("tag_q_empty", 64'(tq.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
